// File: rtl/priority_decoder_pkg.sv
// priority_decoder_pkg: shared widths, FSM state encoding, idle code and line decode helper.
package priority_decoder_pkg;
   localparam int CODE_W = 3;
   localparam int LINES = 8;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      QUALIFY = 2'd1,
      ACTIVE = 2'd2
   } state_t;
   // MSB set marks the idle code, otherwise the low bits carry the line index
   typedef logic [CODE_W:0] code_t;
   localparam code_t IDLE_CODE = code_t'(1 << CODE_W);
   function automatic logic [LINES-1:0] onehot(input code_t c);
      return c[CODE_W] ? '0 : LINES'(1) << c[CODE_W-1:0];
   endfunction
endpackage

// File: rtl/priority_decoder_if.sv
// priority_decoder_if: encoder-side inputs and reconstructed line outputs.
interface priority_decoder_if;
   import priority_decoder_pkg::*;
   logic en;
   logic GS;
   logic EO;
   logic [CODE_W-1:0] A;
   logic [LINES-1:0] sel_n;
   logic valid;
   logic busy;
   logic err;
   modport master(output en, GS, EO, A, input sel_n, valid, busy, err);
   modport slave(input en, GS, EO, A, output sel_n, valid, busy, err);
endinterface

// File: rtl/priority_decoder_stable_cnt.sv
// stable_cnt: saturating run-length counter; hit flags the edge on which MAX is reached.
module stable_cnt #(
   parameter int MAX = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] cnt,
   output logic       hit
);
   always_comb hit = load ? (MAX == 1) : inc && ({1'b0, cnt} + 5'd1 >= 5'(MAX));
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else cnt <= clr ? '0 : load ? 4'd1 : (inc && cnt < 4'(MAX)) ? cnt + 4'd1 : cnt;
endmodule

// File: rtl/priority_decoder.sv
// priority_decoder: rebuilds an active-low one-hot line vector from a priority encoder's outputs,
// updating only after a code has been sampled STABLE_CYCLES times in a row.
module priority_decoder
   import priority_decoder_pkg::*;
#(
   parameter int   STABLE_CYCLES = 4,
   parameter logic IDLE_LEVEL = 1'b1
) (
   input logic clk,
   input logic rst,
   priority_decoder_if.slave bus
);
   code_t samp, pres, pend, pin_code;
   logic samp_ill, ill, load, inc, clr, hit, cancel;
   logic [3:0] cnt;
   state_t state;
   always_comb begin
      ill = !bus.GS && !bus.EO;
      pin_code = (bus.en || bus.GS || ill) ? IDLE_CODE : {1'b0, bus.A};
      cancel = state == QUALIFY && samp == pres;
      load = state == QUALIFY ? samp != pres && samp != pend : samp != pres;
      inc = state == QUALIFY && samp == pend;
      clr = hit || cancel;
   end
   stable_cnt #(.MAX(STABLE_CYCLES)) u_cnt (
      .clk(clk), .rst(rst), .load(load), .inc(inc), .clr(clr), .cnt(cnt), .hit(hit)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         samp <= IDLE_CODE;
         samp_ill <= 1'b0;
         pres <= IDLE_CODE;
         pend <= IDLE_CODE;
         state <= IDLE;
         bus.sel_n <= {LINES{IDLE_LEVEL}};
         bus.valid <= 1'b0;
         bus.busy <= 1'b0;
         bus.err <= 1'b0;
      end else begin
         samp <= pin_code;
         samp_ill <= ill;
         bus.err <= samp_ill;
         bus.valid <= hit;
         if (load) pend <= samp;
         if (hit) begin
            pres <= samp;
            bus.sel_n <= {LINES{IDLE_LEVEL}} ^ onehot(samp);
            state <= samp == IDLE_CODE ? IDLE : ACTIVE;
            bus.busy <= 1'b0;
         end else if (cancel) begin
            state <= pres == IDLE_CODE ? IDLE : ACTIVE;
            bus.busy <= 1'b0;
         end else if (load) begin
            state <= QUALIFY;
            bus.busy <= 1'b1;
         end
      end
endmodule

// File: tb/tb_priority_decoder.sv
// tb_priority_decoder: scoreboard bench; a run-length model predicts each sel_n update.
module tb_priority_decoder;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   priority_decoder_if bus ();
   priority_decoder #(.STABLE_CYCLES(4), .IDLE_LEVEL(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
   int total = 0, bad = 0;
   int n_valid = 0, n_busy = 0, n_err = 0, exp_err = 0;
   int last_code = 8, run = 0, pres = 8, c;
   int v0, b0, e0;
   logic [7:0] expq[$];
   function automatic logic [7:0] want(input int code);
      return code == 8 ? 8'hFF : ~(8'd1 << code);
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask
   task automatic hold(input logic e, input logic g, input logic o, input logic [2:0] a, input int n);
      bus.en = e;
      bus.GS = g;
      bus.EO = o;
      bus.A = a;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   // code 8 stands for idle; an update fires when a differing code has been seen 4 times running
   always @(posedge clk)
      if (!rst) begin
         last_code = 8;
         run = 0;
         pres = 8;
         expq.delete();
      end else begin
         c = (bus.en || bus.GS || !bus.EO) ? 8 : int'(bus.A);
         if (!bus.GS && !bus.EO) exp_err++;
         run = (c == last_code) ? run + 1 : 1;
         last_code = c;
         if (run == 4 && c != pres) begin
            pres = c;
            expq.push_back(want(c));
         end
      end
   always @(negedge clk)
      if (rst) begin
         check("onehot", $countones(~bus.sel_n) <= 1, 1);
         if (bus.valid) begin
            n_valid++;
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_valid: sel_n=%0h required no valid", bus.sel_n);
            end else check("valid_sel", bus.sel_n, expq.pop_front());
         end
         n_busy += int'(bus.busy);
         n_err += int'(bus.err);
      end
   initial begin
      bus.en = 1'b0;
      bus.GS = 1'b0;
      bus.EO = 1'b1;
      bus.A = 3'd5;
      repeat (3) @(posedge clk);
      #1;
      check("reset_sel", bus.sel_n, 8'hFF);
      check("reset_valid", bus.valid, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_err", bus.err, 0);
      rst = 1'b1;
      @(negedge clk);
      check("release_sel", bus.sel_n, 8'hFF);
      check("release_valid", bus.valid, 0);
      @(posedge clk);
      #1;
      check("release1_sel", bus.sel_n, 8'hFF);
      check("release1_valid", bus.valid, 0);
      hold(0, 0, 1, 5, 8);
      check("first_sel", bus.sel_n, 8'hDF);
      v0 = n_valid;
      b0 = n_busy;
      hold(0, 0, 1, 2, 8);
      check("qualify_sel", bus.sel_n, 8'hFB);
      check("qualify_valids", n_valid - v0, 1);
      check("qualify_busy", n_busy - b0, 3);
      v0 = n_valid;
      b0 = n_busy;
      hold(0, 0, 1, 6, 2);
      hold(0, 0, 1, 2, 6);
      check("glitch_sel", bus.sel_n, 8'hFB);
      check("glitch_valids", n_valid - v0, 0);
      check("glitch_busy", bus.busy, 0);
      check("glitch_busy_cycles", n_busy - b0, 2);
      v0 = n_valid;
      e0 = n_err;
      hold(0, 0, 0, 2, 1);
      hold(0, 0, 1, 2, 6);
      check("illegal_err", n_err - e0, 1);
      check("illegal_sel", bus.sel_n, 8'hFB);
      check("illegal_valids", n_valid - v0, 0);
      v0 = n_valid;
      hold(0, 0, 0, 2, 6);
      check("illegal_idle_sel", bus.sel_n, 8'hFF);
      check("illegal_idle_valids", n_valid - v0, 1);
      hold(0, 0, 1, 7, 6);
      check("line7_sel", bus.sel_n, 8'h7F);
      v0 = n_valid;
      hold(1, 0, 1, 7, 6);
      check("disable_sel", bus.sel_n, 8'hFF);
      check("disable_valids", n_valid - v0, 1);
      v0 = n_valid;
      for (int a = 0; a < 8; a++) begin
         hold(0, 0, 1, 3'(a), 6);
         check("sweep_sel", bus.sel_n, want(a));
      end
      check("sweep_valids", n_valid - v0, 8);
      hold(0, 0, 1, 3, 2);
      rst = 1'b0;
      v0 = n_valid;
      hold(0, 0, 1, 3, 2);
      check("midreset_sel", bus.sel_n, 8'hFF);
      rst = 1'b1;
      hold(1, 0, 1, 3, 6);
      check("midreset_valids", n_valid - v0, 0);
      check("midreset_after_sel", bus.sel_n, 8'hFF);
      repeat (300)
         hold($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0,
              3'($urandom_range(0, 7)), $urandom_range(1, 6));
      hold(1, 0, 1, 0, 8);
      check("queue_drained", expq.size(), 0);
      check("err_count", n_err, exp_err);
      check("final_sel", bus.sel_n, want(pres));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/priority_decoder.md
PRIORITY_DECODER -- requirements
Module: priority_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, meaning consecutive identical input samples required before output update (legal range 1..15).
REQ-002 Parameter IDLE_LEVEL, default 1'b1, meaning the inactive level of each sel_n bit (active-low lines).
REQ-003 The clock is one clock and the reset is asynchronous and active-low; the clock port is clk and the reset port is rst.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 en  input  1  active-low enable; 1 forces the idle output.
REQ-007 A  input  3  encoded index of the highest-priority active line.
REQ-008 GS  input  1  active-low group select; 0 means A is meaningful.
REQ-009 EO  input  1  active-low enable-out; 0 means enabled and no line active.
REQ-010 sel_n  output  8  active-low one-hot reconstructed line vector.
REQ-011 valid  output  1  one-cycle pulse on every sel_n update.
REQ-012 busy  output  1  high while a new code is qualifying.
REQ-013 err  output  1  one-cycle pulse on an illegal input combination.

Function
REQ-014 Inputs {en, GS, EO, A} SHALL be registered once (sample stage) before any decision; all latencies count from that sample edge.
REQ-015 Decoded code SHALL be: en=1 or GS=1 -> IDLE code; en=0 and GS=0 -> line A.
REQ-016 GS=0 and EO=0 on the same sample SHALL be illegal: err pulses on the next edge and the sample is treated as IDLE code.
REQ-017 FSM states SHALL be IDLE, QUALIFY, ACTIVE, encoded in 2 bits.
REQ-018 IDLE: sel_n = 8'hFF; a sampled code differing from the presented code -> QUALIFY, stability counter = 1.
REQ-019 QUALIFY: an equal sample increments the counter; a differing sample reloads the counter to 1 and keeps sel_n unchanged.
REQ-020 When the counter reaches STABLE_CYCLES, sel_n SHALL update on that same edge, valid SHALL pulse for one cycle, and the FSM SHALL move to ACTIVE (line code) or IDLE (IDLE code).
REQ-021 ACTIVE: sel_n = ~(8'b1 << A_presented); a differing sample -> QUALIFY while holding sel_n.
REQ-022 A code that returns to the presented value during QUALIFY SHALL cancel qualification: FSM returns to the previous steady state, valid not pulsed.
REQ-023 With STABLE_CYCLES=1, a changed input SHALL appear on sel_n two edges after it is applied to the pins (one sample, one update).
REQ-024 busy SHALL equal (state == QUALIFY).
REQ-025 The counter SHALL saturate at STABLE_CYCLES and never wrap.
REQ-026 sel_n SHALL never have more than one bit low.

Reset
REQ-027 rst=0 SHALL immediately set sel_n=8'hFF, valid=0, busy=0, err=0, state=IDLE, counter=0, and the sample register to the IDLE code.
REQ-028 Reset asserted mid-QUALIFY SHALL discard the pending code; no valid pulse after release.
REQ-029 The first sample after rst release SHALL be treated as a new code only if it differs from the IDLE code.

Structure
REQ-030 Shared package priority_decoder_pkg SHALL hold the state encoding localparams, CODE_W=3, LINES=8, and the IDLE code constant.
REQ-031 The stability counter SHALL be a separate sub-module stable_cnt (load-1, increment, saturate, reached flag).
REQ-032 The output decode SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-033 Reset: rst=0 with A=3'd5, GS=0 -> sel_n=8'hFF, valid=0 during and one cycle after release.
REQ-034 Qualify: en=0, GS=0, EO=1, A=3'd2 held 4 samples -> sel_n=8'hFB, one valid pulse, busy high exactly 3 cycles.
REQ-035 Glitch: A=3'd6 for 2 samples then back to presented 3'd2 -> sel_n stays 8'hFB, no valid, busy cleared.
REQ-036 Illegal: GS=0, EO=0 for one sample -> err pulses once, sel_n unchanged, next steady state IDLE code.
REQ-037 Disable: en=1 while ACTIVE with A=3'd7 held -> after 4 samples sel_n=8'hFF, valid pulses once.
REQ-038 Sweep: A=0..7 each held 6 samples -> sel_n walks 8'hFE..8'h7F, exactly 8 valid pulses, never two bits low.
